// File: rtl/adder_pipelined_pkg.sv
// Shared helpers for adder_pipelined and its arbiter front end: chunk geometry,
// select-width helper and the controller state encoding.
package adder_pipelined_pkg;

  // Chunk width so that LATENCY chunks cover WIDTH bits.
  function automatic int alu_width(input int width, input int latency);
    return (width + latency - 1) / latency;
  endfunction

  // Number of chunks actually needed at that chunk width.
  function automatic int chunk_count(input int width, input int latency);
    int aw;
    aw = alu_width(width, latency);
    return (width + aw - 1) / aw;
  endfunction

  // Index width that stays at least one bit for a single entry.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    WB    = 2'd3
  } state_t;

endpackage

// File: rtl/adder_pipelined_arbiter_if.sv
// Client-side bus of adder_pipelined_arbiter. ADDER_PIPELINED_ARBITER_OVERFLOW_EN
// adds the sticky overflow flags and their clear strobes.
interface adder_pipelined_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 16
);
  import adder_pipelined_pkg::*;

  localparam int SEL_W = sel_width(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] incr;
  logic [N-1:0]       ack;
  logic               busy;
  logic [SEL_W-1:0]   rd_sel;
  logic [WIDTH-1:0]   rd_data;

`ifdef ADDER_PIPELINED_ARBITER_OVERFLOW_EN
  logic [N-1:0]       ovf;
  logic [N-1:0]       ovf_clr;

  modport master (output req, incr, rd_sel, ovf_clr, input ack, busy, rd_data, ovf);
  modport slave  (input req, incr, rd_sel, ovf_clr, output ack, busy, rd_data, ovf);
`else
  modport master (output req, incr, rd_sel, input ack, busy, rd_data);
  modport slave  (input req, incr, rd_sel, output ack, busy, rd_data);
`endif

endinterface

// File: rtl/adder_pipelined.sv
// Chunked adder: ce loads the addend and clears inter-chunk carries; each later
// cycle adds the pending carries to d, so C cycles of q->d feedback finish the sum.
module adder_pipelined
  import adder_pipelined_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             ce,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  localparam int AW = alu_width(WIDTH, LATENCY);
  localparam int C  = chunk_count(WIDTH, LATENCY);
  localparam int PW = AW * C;

  logic [PW-1:0] addend;
  logic [C-1:0]  carry;
  logic [PW-1:0] d_pad;
  logic [PW-1:0] sum_pad;
  logic [C-1:0]  cout;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    d_pad   = PW'(d);
    sum_pad = '0;
    cout    = '0;
    for (int j = 0; j < C; j++) begin
      {cout[j], sum_pad[j*AW +: AW]} = {1'b0, d_pad[j*AW +: AW]}
                                     + {1'b0, addend[j*AW +: AW]}
                                     + (AW+1)'(carry[j]);
    end
  end

  assign q = sum_pad[WIDTH-1:0];

  // NOTE: no reset here; ce rewrites both registers before q is ever consumed.
  always_ff @(posedge clk) begin
    if (ce) begin
      addend <= PW'(i);
      carry  <= '0;
    end else begin
      addend <= '0;
      carry  <= cout << 1;
    end
  end

endmodule

// File: rtl/adder_pipelined_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx
);

  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (grant == '0 && req[k]) begin
        grant[k] = 1'b1;
        idx      = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/adder_pipelined_arbiter.sv
// N accumulators sharing one adder_pipelined under round-robin arbitration.
// Define ADDER_PIPELINED_ARBITER_OVERFLOW_EN for sticky per-accumulator wrap flags.
module adder_pipelined_arbiter
  import adder_pipelined_pkg::*;
#(
  parameter int N       = 4,
  parameter int WIDTH   = 16,
  parameter int LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  adder_pipelined_arbiter_if.slave  bus
);
  localparam int C     = chunk_count(WIDTH, LATENCY);
  localparam int SEL_W = sel_width(N);
  localparam int CNT_W = sel_width(C);

  state_t           state, next_state;
  logic [WIDTH-1:0] acc [N];
  logic [WIDTH-1:0] work, r_inc, q;
  logic [SEL_W-1:0] g, ptr, gnt_idx;
  logic [N-1:0]     gnt;
  logic [CNT_W-1:0] cnt;
  logic             ce;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  adder_pipelined #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_add (
    .clk (clk),
    .ce  (ce),
    .i   (r_inc),
    .d   (work),
    .q   (q)
  );

  always_comb begin
    next_state = state;
    ce         = 1'b0;
    bus.ack    = '0;
    bus.busy   = (state != IDLE);
    case (state)
      IDLE:    if (|gnt) next_state = ISSUE;
      ISSUE: begin
        ce         = 1'b1;
        next_state = RUN;
      end
      RUN:     if (cnt == '0) next_state = WB;
      WB: begin
        bus.ack[g] = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      g     <= '0;
      r_inc <= '0;
      work  <= '0;
      cnt   <= '0;
      // NOTE: the accumulator file is cleared by reset because clients read it
      // as committed state; a loop keeps this independent of N.
      for (int k = 0; k < N; k++) acc[k] <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (|gnt) begin
          g     <= gnt_idx;
          r_inc <= bus.incr[int'(gnt_idx)*WIDTH +: WIDTH];
          work  <= acc[gnt_idx];
        end
        ISSUE: cnt <= CNT_W'(C - 1);
        RUN: begin
          work <= q;
          cnt  <= cnt - CNT_W'(1);
        end
        WB: begin
          acc[g] <= work;
          ptr    <= (g == SEL_W'(N - 1)) ? '0 : g + SEL_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < N; k++)
      if (bus.rd_sel == SEL_W'(k)) bus.rd_data = acc[k];
  end

`ifdef ADDER_PIPELINED_ARBITER_OVERFLOW_EN
  logic [N-1:0] ovf_q;

  // A clear coinciding with the ack drops history; a wrap in that same op re-arms.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (state == WB) begin
      ovf_q[g] <= (ovf_q[g] & ~bus.ovf_clr[g]) | (work < acc[g]);
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipelined_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a
// randomized phase against a round-robin/accumulator reference model.
module tb_adder_pipelined_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int L  = 4;
  localparam int C  = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  adder_pipelined_arbiter_if #(.N(N), .WIDTH(W)) bus ();

  adder_pipelined_arbiter #(.N(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         k;
    logic [15:0] inc;
    logic [15:0] exp;
    int         other;
    logic [15:0] other_exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.req    = '0;
    bus.incr   = '0;
    bus.rd_sel = '0;
`ifdef ADDER_PIPELINED_ARBITER_OVERFLOW_EN
    bus.ovf_clr = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic read_acc(input int k, input logic [15:0] exp, input string name);
    bus.rd_sel = 2'(k);
    #1 check(name, bus.rd_data, exp);
  endtask

  // Counts negedges after the sampling edge until ack appears (bounded).
  task automatic wait_ack(input int k, input int exp_lat, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack == '0 && n < 40);
    check({name, " ack"}, bus.ack, 32'(4'b0001 << k));
    if (exp_lat > 0) check({name, " latency"}, n, exp_lat);
  endtask

  // One isolated op on requester k; leaves the DUT idle in an IDLE cycle.
  task automatic apply(input int k, input logic [15:0] inc, input logic [15:0] exp,
                       input string name);
    @(posedge clk);
    #1;
    bus.req[k]            = 1'b1;
    bus.incr[k*W +: W]    = inc;
    @(posedge clk);
    wait_ack(k, 6, name);
    bus.req[k] = 1'b0;
    @(negedge clk);
    read_acc(k, exp, {name, " acc"});
    check({name, " idle busy"}, 32'(bus.busy), 32'd0);
  endtask

  function automatic int rr_pick(input logic [3:0] p, input int ptr);
    for (int i = 0; i < N; i++)
      if (p[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  vec_t vecs[8];

  initial begin
    logic [15:0] macc [N];
    logic [15:0] minc [N];
    logic [3:0]  pend;
    int          mptr, exp_k, wait_cnt, n, sel;
    bit          acked;

    vecs[0] = '{2, 16'h00FF, 16'h00FF, 0, 16'h0000};
    vecs[1] = '{0, 16'h0FFF, 16'h0FFF, 1, 16'h0000};
    vecs[2] = '{0, 16'h0001, 16'h1000, 2, 16'h00FF};
    vecs[3] = '{1, 16'hFFFF, 16'hFFFF, 0, 16'h1000};
    vecs[4] = '{1, 16'h0002, 16'h0001, 3, 16'h0000};
    vecs[5] = '{3, 16'h0000, 16'h0000, 1, 16'h0001};
    vecs[6] = '{3, 16'hBEEF, 16'hBEEF, 2, 16'h00FF};
    vecs[7] = '{2, 16'hFF01, 16'h0000, 3, 16'hBEEF};

    // Reset state.
    do_reset();
    @(negedge clk);
    check("reset ack", bus.ack, 0);
    check("reset busy", 32'(bus.busy), 0);
    for (int k = 0; k < N; k++) read_acc(k, 16'h0000, "reset acc");

    // Directed vector table.
    for (int v = 0; v < 8; v++) begin
      apply(vecs[v].k, vecs[v].inc, vecs[v].exp, $sformatf("vec%0d", v));
      read_acc(vecs[v].other, vecs[v].other_exp, $sformatf("vec%0d other", v));
`ifdef ADDER_PIPELINED_ARBITER_OVERFLOW_EN
      if (v == 4) begin
        check("ovf set on wrap", 32'(bus.ovf), 32'b0010);
      end
`endif
    end

`ifdef ADDER_PIPELINED_ARBITER_OVERFLOW_EN
    apply(0, 16'h0001, 16'h1001, "ovf hold");
    check("ovf sticky", 32'(bus.ovf[1]), 1);
    bus.ovf_clr[1] = 1'b1;
    apply(1, 16'h0000, 16'h0001, "ovf clear");
    bus.ovf_clr[1] = 1'b0;
    check("ovf cleared", 32'(bus.ovf[1]), 0);
`endif

    // Fairness: all four held, acks rotate 0,1,2,3,0 spaced C+3 cycles.
    do_reset();
    @(posedge clk);
    #1;
    bus.req = 4'hF;
    for (int k = 0; k < N; k++) bus.incr[k*W +: W] = 16'(k + 1);
    @(posedge clk);
    for (int a = 0; a < 5; a++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.ack == '0 && n < 40);
      check($sformatf("fair ack%0d", a), bus.ack, 32'(4'b0001 << (a % N)));
      check($sformatf("fair gap%0d", a), n, (a == 0) ? 6 : C + 3);
      if (a == 4) bus.req = '0;
    end
    @(negedge clk);
    read_acc(0, 16'h0002, "fair acc0");
    read_acc(3, 16'h0004, "fair acc3");

    // Abort: reset during RUN of requester 3.
    do_reset();
    apply(0, 16'h0042, 16'h0042, "pre-abort");
    @(posedge clk);
    #1;
    bus.req[3]         = 1'b1;
    bus.incr[3*W +: W] = 16'h0777;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("abort busy in run", 32'(bus.busy), 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort no ack", bus.ack, 0);
    end
    bus.req = '0;
    rst     = 1'b0;
    check("abort busy", 32'(bus.busy), 0);
    for (int k = 0; k < N; k++) read_acc(k, 16'h0000, "abort acc");
    apply(3, 16'h0005, 16'h0005, "post-abort");

    // Late incr change and req drop right after grant.
    do_reset();
    @(posedge clk);
    #1;
    bus.req[1]         = 1'b1;
    bus.incr[1*W +: W] = 16'h0010;
    @(posedge clk);
    #1;
    bus.incr[1*W +: W] = 16'hABCD;
    bus.req[1]         = 1'b0;
    wait_ack(1, 6, "late");
    @(negedge clk);
    read_acc(1, 16'h0010, "late acc");

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < N; k++) begin
      macc[k] = '0;
      minc[k] = '0;
    end
    pend     = '0;
    mptr     = 0;
    exp_k    = -1;
    wait_cnt = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      sel        = $urandom_range(0, N - 1);
      bus.rd_sel = 2'(sel);
      #1 check("rand rd", bus.rd_data, macc[sel]);
      acked = 1'b0;
      if (bus.ack != '0) begin
        if (exp_k < 0) begin
          check("rand spurious ack", bus.ack, 0);
        end else begin
          check("rand grant", bus.ack, 32'(4'b0001 << exp_k));
          macc[exp_k]     = macc[exp_k] + minc[exp_k];
          mptr            = (exp_k + 1) % N;
          pend[exp_k]     = 1'b0;
          bus.req[exp_k]  = 1'b0;
          acked           = 1'b1;
        end
      end
      if (acked || pend == '0) begin
        for (int k = 0; k < N; k++) begin
          if (!pend[k] && $urandom_range(0, 2) == 0) begin
            pend[k]            = 1'b1;
            minc[k]            = 16'($urandom);
            bus.req[k]         = 1'b1;
            bus.incr[k*W +: W] = minc[k];
          end
        end
        exp_k    = rr_pick(pend, mptr);
        wait_cnt = 0;
      end else if (pend != '0) begin
        wait_cnt++;
        if (wait_cnt > C + 3) begin
          check("rand ack timeout", bus.ack, 32'(4'b0001 << exp_k));
          break;
        end
      end
    end
    bus.req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
